// File: rtl/uart_s2p_pkg.sv
// -----------------------------------------------------------------------------
// uart_s2p_pkg
// Shared constants for the UART byte-to-word packer:
//   - asm_state_t      : assembly state encoding (IDLE = no bytes held,
//                        COLLECT = partial word held)
//   - CLKS_PER_BIT     : default UART bit period in clocks (217)
//   - DEF_TIMEOUT_CLKS : default mid-word idle timeout, one full 10-bit frame
//   - byte_cnt_width() : width of the held-byte counter for a given word size
// -----------------------------------------------------------------------------
package uart_s2p_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } asm_state_t;

    localparam int unsigned CLKS_PER_BIT     = 217;
    localparam int unsigned BITS_PER_FRAME   = 10;
    localparam int unsigned DEF_TIMEOUT_CLKS = CLKS_PER_BIT * BITS_PER_FRAME;

    // Counter holds 0..n-1; never narrower than one bit.
    function automatic int byte_cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// -----------------------------------------------------------------------------
// uart_word_fifo
// Small synchronous word FIFO, first-word-fall-through.
//   P_WIDTH : word width in bits
//   P_DEPTH : entries, power of two (2..16)
// Ports:
//   i_Clk, i_Rst_n : clock, async active-low reset (empties the FIFO)
//   i_Push, i_Data : write request and data; accepted when not full, or when
//                    full and a pop is accepted on the same edge
//   i_Pop          : read request; ignored while empty
//   o_Data         : head word, forced to 0 while empty
//   o_Full, o_Empty: occupancy flags
// -----------------------------------------------------------------------------
module uart_word_fifo #(
    parameter int P_WIDTH = 32,
    parameter int P_DEPTH = 4
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_Push,
    input  logic [P_WIDTH-1:0] i_Data,
    input  logic               i_Pop,
    output logic [P_WIDTH-1:0] o_Data,
    output logic               o_Full,
    output logic               o_Empty
);

    localparam int AW   = $clog2(P_DEPTH);
    localparam int CNTW = AW + 1;

    logic [P_WIDTH-1:0] mem [P_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    // One bit wider than the pointers so "full" and "empty" are distinct.
    logic [CNTW-1:0]    count;
    logic               push_ok;
    logic               pop_ok;

    assign o_Empty = (count == '0);
    assign o_Full  = (count == CNTW'(P_DEPTH));
    assign pop_ok  = i_Pop && !o_Empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push_ok = i_Push && (!o_Full || pop_ok);
    assign o_Data  = o_Empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally: depth is a power of two.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: o_Data is masked while empty.
    always_ff @(posedge i_Clk) begin
        if (push_ok) mem[wr_ptr] <= i_Data;
    end

endmodule

// File: rtl/uart_rx_word_packer.sv
// -----------------------------------------------------------------------------
// uart_rx_word_packer
// Packs single-cycle byte strobes from a UART receiver into little-endian
// words (first byte in bits [7:0]) and buffers them in a small FIFO.
//
// Parameters:
//   P_BYTES_PER_WORD : bytes per output word (2..8)
//   P_FIFO_DEPTH     : output FIFO entries (power of two, 2..16)
//   P_TIMEOUT_CLKS   : mid-word idle clocks before a partial word is dropped
//
// Ports:
//   i_Clk, i_Rst_n           : clock, async active-low reset
//   i_Rx_ByteValid, i_Rx_Byte: byte strobe and data from the receiver
//   o_Word_Valid, o_Word     : FIFO not empty / head word
//   i_Word_Ready             : consumer pops the head when o_Word_Valid is high
//   o_Overflow               : sticky, a completed word was dropped (FIFO full)
//   i_Overflow_Clr           : synchronous clear of o_Overflow (set wins)
//   o_Timeout                : one-cycle pulse, a partial word was discarded
//
// Build option:
//   UART_RX_WORD_TIMEOUT_EN  : when defined, a partial word idle for
//                              P_TIMEOUT_CLKS clocks is discarded. When not
//                              defined, partial words are held indefinitely
//                              and o_Timeout is tied low.
// -----------------------------------------------------------------------------
module uart_rx_word_packer
    import uart_s2p_pkg::*;
#(
    parameter int P_BYTES_PER_WORD = 4,
    parameter int P_FIFO_DEPTH     = 4,
    parameter int P_TIMEOUT_CLKS   = DEF_TIMEOUT_CLKS
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_n,
    input  logic                          i_Rx_ByteValid,
    input  logic [7:0]                    i_Rx_Byte,
    output logic                          o_Word_Valid,
    input  logic                          i_Word_Ready,
    output logic [8*P_BYTES_PER_WORD-1:0] o_Word,
    output logic                          o_Overflow,
    input  logic                          i_Overflow_Clr,
    output logic                          o_Timeout
);

    localparam int CW = byte_cnt_width(P_BYTES_PER_WORD);
    localparam int WW = 8 * P_BYTES_PER_WORD;
    localparam logic [CW-1:0] LAST_IDX = CW'(P_BYTES_PER_WORD - 1);

    asm_state_t                       state;
    logic [CW-1:0]                    byte_cnt;
    logic [P_BYTES_PER_WORD-1:0][7:0] asm_word;
    // Completed-word write strobe, one edge behind the last byte.
    logic                             push_q;
    logic                             fifo_full;
    logic                             fifo_empty;
    logic                             pop;

`ifdef UART_RX_WORD_TIMEOUT_EN
    localparam int TW = $clog2(P_TIMEOUT_CLKS + 1);
    logic [TW-1:0] tmo_cnt;
`else
    assign o_Timeout = 1'b0;
`endif

    assign o_Word_Valid = !fifo_empty;
    assign pop          = o_Word_Valid && i_Word_Ready;

    // -------------------------------------------------------------------------
    // Assembly FSM. The FIFO samples asm_word on the edge after the last byte
    // lands; a new word's first byte written on that same edge only touches
    // lane 0 through a non-blocking update, so back-to-back strobes are safe.
    // Bytes left in upper lanes by a discarded word are always overwritten
    // before the next push.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
            asm_word <= '0;
            push_q   <= 1'b0;
`ifdef UART_RX_WORD_TIMEOUT_EN
            tmo_cnt   <= '0;
            o_Timeout <= 1'b0;
`endif
        end else begin
            push_q <= 1'b0;
`ifdef UART_RX_WORD_TIMEOUT_EN
            o_Timeout <= 1'b0;
`endif
            // A strobe always takes priority over timeout expiry.
            if (i_Rx_ByteValid) begin
                asm_word[byte_cnt] <= i_Rx_Byte;
`ifdef UART_RX_WORD_TIMEOUT_EN
                tmo_cnt <= '0;
`endif
                if (state == ST_IDLE) begin
                    state    <= ST_COLLECT;
                    byte_cnt <= CW'(1);
                end else if (byte_cnt == LAST_IDX) begin
                    state    <= ST_IDLE;
                    byte_cnt <= '0;
                    push_q   <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + CW'(1);
                end
            end
`ifdef UART_RX_WORD_TIMEOUT_EN
            else if (state == ST_COLLECT) begin
                if (tmo_cnt == TW'(P_TIMEOUT_CLKS - 1)) begin
                    state     <= ST_IDLE;
                    byte_cnt  <= '0;
                    tmo_cnt   <= '0;
                    o_Timeout <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Overflow: a push that the FIFO cannot take (full, no pop this edge).
    // -------------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Overflow <= 1'b0;
        end else if (push_q && fifo_full && !pop) begin
            o_Overflow <= 1'b1;
        end else if (i_Overflow_Clr) begin
            o_Overflow <= 1'b0;
        end
    end

    uart_word_fifo #(
        .P_WIDTH (WW),
        .P_DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Push  (push_q),
        .i_Data  (asm_word),
        .i_Pop   (pop),
        .o_Data  (o_Word),
        .o_Full  (fifo_full),
        .o_Empty (fifo_empty)
    );

endmodule

// File: doc/uart_rx_word_packer.md
UART_RX_WORD_PACKER -- requirements
Module: uart_rx_word_packer

Interface
REQ-001 The block SHALL have parameter P_BYTES_PER_WORD, default 4: bytes assembled per output word (legal 2..8).
REQ-002 The block SHALL have parameter P_FIFO_DEPTH, default 4: output word FIFO entries (power of two, 2..16).
REQ-003 The block SHALL have parameter P_TIMEOUT_CLKS, default 2170: idle clocks mid-word before the partial word is discarded (10 bit times at 217 clocks/bit).
REQ-004 The block SHALL have port i_Clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port i_Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port i_Rx_ByteValid, input, 1 bit: one-cycle strobe from the UART receiver marking a completed byte.
REQ-007 The block SHALL have port i_Rx_Byte, input, 8 bits: received byte, valid while i_Rx_ByteValid is high.
REQ-008 The block SHALL have port o_Word_Valid, output, 1 bit: high while the FIFO is not empty.
REQ-009 The block SHALL have port i_Word_Ready, input, 1 bit: consumer accepts o_Word when high together with o_Word_Valid.
REQ-010 The block SHALL have port o_Word, output, 8*P_BYTES_PER_WORD bits: the FIFO head word.
REQ-011 The block SHALL have port o_Overflow, output, 1 bit: sticky flag meaning a completed word was dropped.
REQ-012 The block SHALL have port i_Overflow_Clr, input, 1 bit: synchronous clear of o_Overflow.
REQ-013 The block SHALL have port o_Timeout, output, 1 bit: one-cycle pulse meaning a partial word was discarded.

Function
REQ-014 The block SHALL use an assembly state machine with states IDLE (0 bytes held) and COLLECT (1..P_BYTES_PER_WORD-1 bytes held).
REQ-015 The block SHALL place byte index i (0 = first received) at o_Word bits [8i+7:8i], so the first byte is least significant.
REQ-016 The block SHALL transition as follows: IDLE -> COLLECT on a strobe; COLLECT -> COLLECT on a strobe that is not the last byte; on the Nth byte, return to IDLE with the byte count reset to 0.
REQ-017 The block SHALL write the completed word into the FIFO at the clock edge following the edge that sampled the Nth strobe, so o_Word_Valid rises 2 edges after the Nth strobe is sampled when the FIFO is empty.
REQ-018 The block SHALL pop the FIFO on an edge where o_Word_Valid and i_Word_Ready are both high; o_Word SHALL be stable while o_Word_Valid is high and i_Word_Ready is low.
REQ-019 When the FIFO is full and a pop and push coincide, the block SHALL accept both, leaving the count unchanged.
REQ-020 When the FIFO is full and a push occurs without a pop, the block SHALL drop the word, keep the FIFO contents intact, and set o_Overflow.
REQ-021 When an overflow set and i_Overflow_Clr coincide, set SHALL win.
REQ-022 The block SHALL wrap FIFO read/write pointers modulo P_FIFO_DEPTH and use an extra count bit to distinguish full from empty.
REQ-023 The block SHALL accept back-to-back strobes on consecutive cycles without loss.

Reset
REQ-024 While i_Rst_n is low, the block SHALL hold state IDLE, byte count 0, FIFO empty, o_Word_Valid 0, o_Word 0, o_Overflow 0, o_Timeout 0, and the timeout counter 0.
REQ-025 Reset asserted mid-word or with a non-empty FIFO SHALL discard all held data; no word SHALL be emitted after reset release until P_BYTES_PER_WORD new strobes arrive.

Configuration
REQ-026 With macro UART_RX_WORD_TIMEOUT_EN defined, a counter SHALL run in COLLECT and clear on each strobe; on reaching P_TIMEOUT_CLKS, the block SHALL discard the partial word, return to IDLE, and pulse o_Timeout for one cycle.
REQ-027 When a strobe coincides with timeout expiry, the strobe SHALL win: the byte is kept, the counter is cleared, and no timeout fires.
REQ-028 Without UART_RX_WORD_TIMEOUT_EN, the block SHALL contain no counter logic, SHALL tie o_Timeout to 0, and SHALL hold partial words indefinitely.

Structure
REQ-029 Package uart_s2p_pkg SHALL hold the state encoding constants, the default clocks-per-bit (217), and the derived default timeout constant.
REQ-030 The FIFO SHALL be a separate sub-module, uart_word_fifo, parameterised by width and depth, with push/pop/full/empty ports.

Verification
REQ-031 A bench SHALL drive strobes 0x11, 0x22, 0x33, 0x44 with i_Word_Ready=1 and require o_Word=0x44332211 with o_Word_Valid high for exactly one cycle, 2 edges after the 4th strobe.
REQ-032 A bench SHALL hold i_Word_Ready=0 and send 5 words with depth 4, then require o_Overflow=1, the first 4 words drained intact in order, and the 5th absent.
REQ-033 A bench SHALL send bytes 0xAA, 0xBB, idle for 2170 clocks, then send 4 bytes 01..04, and require one o_Timeout pulse and a single output 0x04030201 (macro defined).
REQ-034 A bench SHALL assert i_Rst_n low after 3 bytes, then release and send 4 bytes 05..08, and require a single output 0x08070605 with no stale word.
REQ-035 A bench SHALL fill the FIFO, then complete a push on the same edge as a pop, and require no overflow, count still 4, and correct order.
REQ-036 A bench SHALL send 8 back-to-back single-cycle strobes and require two words output in order.
